// File: rtl/act_pool_unit.sv
// act_pool_unit: LeakyReLU activation followed by optional 2:1 max-pool along position,
// with valid/ready handshakes on both ports and an IDLE/RUN/DONE frame controller.
module act_pool_unit #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_LEN   = 16,
  parameter int NUM_CH      = 4,
  parameter int POOL        = 2,
  parameter int LEAKY_SHIFT = 2,
  parameter int ACT_EN      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  busy,
  output logic                  done
);
  localparam int NOUT = NUM_CH * FRAME_LEN / POOL;
  localparam int PW   = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  localparam int CHW  = $clog2(NUM_CH + 1);
  localparam int OW   = $clog2(NOUT + 1);
  localparam logic [PW-1:0]  PLAST = PW'(FRAME_LEN - 1);
  localparam logic [CHW-1:0] CHEND = CHW'(NUM_CH);
  localparam logic [OW-1:0]  OLAST = OW'(NOUT - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] pos;
  logic [CHW-1:0] ch;
  logic [OW-1:0] out_cnt;
  logic signed [DATA_WIDTH-1:0] held, act, pooled;
  logic accept, win_done, emit, out_xfer, last_out;
  assign act      = (ACT_EN != 0 && data_in[DATA_WIDTH-1]) ? $signed(data_in) >>> LEAKY_SHIFT : $signed(data_in);
  assign win_done = POOL == 1 || pos[0];
  assign pooled   = POOL == 1 ? act : (act > held ? act : held);
  assign accept   = data_ready && data_valid;
  assign emit     = accept && win_done;
  assign out_xfer = data_out_valid && data_out_ready;
  assign last_out = out_xfer && out_cnt == OLAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx   = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last_out ? DONE : RUN) : IDLE;
    busy       = state == RUN;
    done       = state == DONE;
    data_ready = state == RUN && ch != CHEND && (!data_out_valid || data_out_ready);
  end
  // ch reaches NUM_CH exactly when the last input of the frame has been accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pos            <= '0;
      ch             <= '0;
      out_cnt        <= '0;
      held           <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else if (state == IDLE && start) begin
      pos     <= '0;
      ch      <= '0;
      out_cnt <= '0;
      held    <= '0;
    end else begin
      if (accept) begin
        pos <= pos == PLAST ? '0 : pos + 1'b1;
        ch  <= pos == PLAST ? ch + 1'b1 : ch;
        if (!win_done) held <= act;
      end
      if (out_xfer) out_cnt <= out_cnt + 1'b1;
      if (emit) begin
        data_out       <= pooled;
        data_out_valid <= 1'b1;
      end else if (out_xfer) data_out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_act_pool_unit.sv
// tb_act_pool_unit: directed table frame, stall/reset sequences and randomized frames
// against an arithmetic reference for a pooled (default) and a bypass configuration.
module tb_act_pool_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic st[2], dv[2], dor[2], dr[2], dov[2], bsy[2], dn[2];
  logic [15:0] din[2], dout[2];
  always #5 clk = ~clk;
  act_pool_unit u0 (.clk(clk), .rst_n(rst_n), .start(st[0]), .data_in(din[0]), .data_valid(dv[0]),
    .data_ready(dr[0]), .data_out(dout[0]), .data_out_valid(dov[0]), .data_out_ready(dor[0]),
    .busy(bsy[0]), .done(dn[0]));
  act_pool_unit #(.FRAME_LEN(4), .NUM_CH(2), .POOL(1)) u1 (.clk(clk), .rst_n(rst_n), .start(st[1]),
    .data_in(din[1]), .data_valid(dv[1]), .data_ready(dr[1]), .data_out(dout[1]),
    .data_out_valid(dov[1]), .data_out_ready(dor[1]), .busy(bsy[1]), .done(dn[1]));
  int checks = 0, errors = 0;
  logic [15:0] smp[64];
  logic [15:0] exp_q[$];
  typedef struct {logic [15:0] a, b, y;} vec_t;
  vec_t tbl[8];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  // LeakyReLU with slope 1/4 as floor division
  function automatic int act_ref(input logic [15:0] v);
    int x;
    x = int'($signed(v));
    return x < 0 ? (x - 3) / 4 : x;
  endfunction
  task automatic build_exp(input int n, input int p);
    int m;
    exp_q.delete();
    for (int i = 0; i < n; i += p) begin
      m = act_ref(smp[i]);
      if (p == 2 && act_ref(smp[i+1]) > m) m = act_ref(smp[i+1]);
      exp_q.push_back(16'(m));
    end
  endtask
  task automatic rand_smp();
    for (int i = 0; i < 64; i++) smp[i] = 16'($urandom);
  endtask
  // mode 0: steady flow, 1: random gaps/backpressure/start noise, 2: 5-cycle output stall
  task automatic run_frame(input int d, input int mode);
    int n, p, idx, got, cyc, stalls;
    logic seen, hold;
    logic [15:0] prev;
    n = d == 0 ? 64 : 8;
    p = d == 0 ? 2 : 1;
    idx = 0; got = 0; cyc = 0; stalls = 0; seen = 0; hold = 0; prev = '0;
    dv[d] = 0; dor[d] = 1;
    st[d] = 1;
    @(posedge clk); #1;
    st[d] = 0;
    while (!seen && cyc < 2000) begin
      dv[d]  = idx < n && (mode != 1 || $urandom_range(0, 2) != 0);
      din[d] = idx < n ? smp[idx] : 16'h0;
      dor[d] = mode == 1 ? ($urandom_range(0, 2) != 0) : mode == 2 ? !(cyc >= 4 && cyc < 9) : 1'b1;
      st[d]  = mode == 1 && $urandom_range(0, 7) == 0;
      @(negedge clk);
      if (cyc == 0) chk("busy_run", 32'(bsy[d]), 1);
      if (hold) begin
        chk("hold_data", 32'(dout[d]), 32'(prev));
        chk("hold_valid", 32'(dov[d]), 1);
      end
      if (dov[d] && !dor[d]) begin
        chk("ready_stall", 32'(dr[d]), 0);
        stalls++;
      end
      if (dr[d] && dv[d]) idx++;
      if (dov[d] && dor[d]) begin
        if (got < exp_q.size()) chk($sformatf("d%0d_out%0d", d, got), 32'(dout[d]), 32'(exp_q[got]));
        else chk("extra_out", got, exp_q.size());
        got++;
      end
      if (dn[d]) begin
        seen = 1;
        chk("done_outs", got, n / p);
        chk("done_ins", idx, n);
        if (mode == 0) chk("frame_cycles", cyc, n + 1);
      end
      hold = dov[d] && !dor[d];
      prev = dout[d];
      @(posedge clk); #1;
      cyc++;
    end
    dv[d] = 0; st[d] = 0; dor[d] = 1;
    if (!seen) chk("done_timeout", cyc, 0);
    else begin
      @(negedge clk);
      chk("done_pulse", 32'(dn[d]), 0);
      chk("busy_after", 32'(bsy[d]), 0);
    end
    if (mode == 2) chk("stall_cycles", stalls, 5);
  endtask
  task automatic reset_check(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_dout"}, 32'(dout[d]), 0);
      chk({tag, "_dov"}, 32'(dov[d]), 0);
      chk({tag, "_busy"}, 32'(bsy[d]), 0);
      chk({tag, "_done"}, 32'(dn[d]), 0);
      chk({tag, "_ready"}, 32'(dr[d]), 0);
    end
  endtask
  initial begin
    int acc;
    for (int d = 0; d < 2; d++) begin
      st[d] = 0; dv[d] = 0; dor[d] = 1; din[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1 reset_check("rst");
    @(negedge clk) rst_n = 1;
    dv[0] = 1; din[0] = 16'h1234;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", 32'(dr[0]), 0);
      chk("idle_dov", 32'(dov[0]), 0);
    end
    dv[0] = 0;
    tbl[0] = '{16'h0000, 16'hFF00, 16'h0000};
    tbl[1] = '{16'h0100, 16'hFF00, 16'h0100};
    tbl[2] = '{16'h0080, 16'h0200, 16'h0200};
    tbl[3] = '{16'hFE00, 16'hFC00, 16'hFF80};
    tbl[4] = '{16'hFFFF, 16'hFFFD, 16'hFFFF};
    tbl[5] = '{16'h8000, 16'h8000, 16'hE000};
    tbl[6] = '{16'hFFFC, 16'h0003, 16'h0003};
    tbl[7] = '{16'h0005, 16'h7FFF, 16'h7FFF};
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      smp[2*i]   = tbl[i % 8].a;
      smp[2*i+1] = tbl[i % 8].b;
      exp_q.push_back(tbl[i % 8].y);
    end
    run_frame(0, 0);
    rand_smp(); build_exp(64, 2); run_frame(0, 2);
    repeat (3) begin
      rand_smp(); build_exp(64, 2); run_frame(0, 1);
    end
    repeat (4) begin
      rand_smp(); build_exp(8, 1); run_frame(1, 1);
    end
    rand_smp();
    st[0] = 1;
    @(posedge clk); #1;
    st[0] = 0; dv[0] = 1; dor[0] = 1; acc = 0;
    while (acc < 10) begin
      din[0] = smp[acc];
      @(negedge clk);
      if (dr[0]) acc++;
      @(posedge clk); #1;
    end
    #2 rst_n = 0;
    #1 reset_check("midrst");
    @(negedge clk) rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      chk("stale_dov", 32'(dov[0]), 0);
      chk("stale_ready", 32'(dr[0]), 0);
    end
    dv[0] = 0;
    @(posedge clk); #1;
    rand_smp(); build_exp(64, 2); run_frame(0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/act_pool_unit.md
ACT_POOL_UNIT -- requirements
Module: act_pool_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 16: sample width, signed Q8.8.
REQ-002 Parameter FRAME_LEN, default 16: samples per channel on input; SHALL be even when POOL=2.
REQ-003 Parameter NUM_CH, default 4: channels per frame, channel-major order (ch0 pos0..FRAME_LEN-1, then ch1 ...).
REQ-004 Parameter POOL, default 2: max-pool window along position, 1 (bypass) or 2.
REQ-005 Parameter LEAKY_SHIFT, default 2: LeakyReLU negative slope = 2^-LEAKY_SHIFT.
REQ-006 Parameter ACT_EN, default 1: 1 = LeakyReLU applied, 0 = identity.
REQ-007 clk  input  1  clock, rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 start  input  1  single-cycle frame start request.
REQ-010 data_in  input  DATA_WIDTH  conv output sample (signed Q8.8).
REQ-011 data_valid  input  1  data_in valid.
REQ-012 data_ready  output  1  block accepts data_in this cycle.
REQ-013 data_out  output  DATA_WIDTH  activated/pooled sample (signed Q8.8).
REQ-014 data_out_valid  output  1  data_out valid.
REQ-015 data_out_ready  input  1  downstream accepts data_out.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  single-cycle pulse in DONE.

Function
REQ-018 States SHALL be IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when all NUM_CH*FRAME_LEN inputs accepted and the last output transferred (data_out_valid && data_out_ready); DONE->IDLE unconditionally next cycle.
REQ-019 start SHALL be ignored in RUN and DONE; on IDLE->RUN all counters and the pool holding register SHALL clear.
REQ-020 A transfer on either port occurs only when valid and ready are both high on a rising edge.
REQ-021 data_ready SHALL be high only in RUN, while input count < NUM_CH*FRAME_LEN, and (data_out_valid==0 or data_out_ready==1); it SHALL not depend combinationally on data_valid.
REQ-022 Activation (combinational on data_in): x>=0 -> x; x<0 -> x>>>LEAKY_SHIFT (arithmetic shift, floor toward -inf, e.g. -1 -> -1, -256 -> -64); ACT_EN=0 -> x unchanged.
REQ-023 POOL=2: first accepted sample of each pair (even position) SHALL be stored in a holding register, no output; second sample SHALL produce signed max(held, current) loaded into the output register; ties yield that value.
REQ-024 Pairs SHALL never span a channel boundary; position counter wraps at FRAME_LEN-1 to 0 and channel counter increments.
REQ-025 POOL=1: every accepted sample SHALL load the output register directly.
REQ-026 Latency: sample completing a window accepted at edge N -> data_out_valid high after edge N (visible cycle N+1); output register holds data_out stable while data_out_valid && !data_out_ready.
REQ-027 Simultaneous output-complete and output-consume in one cycle SHALL reload the register with data_out_valid held high (no bubble); throughput one output per cycle for POOL=1, one per two inputs for POOL=2.
REQ-028 Output order SHALL match input order: NUM_CH*FRAME_LEN/POOL outputs, channel-major.
REQ-029 No saturation is required: activation and max cannot exceed input range.
REQ-030 busy = (state==RUN); done high exactly one cycle per frame.
REQ-031 data_valid in IDLE or DONE SHALL be ignored (data_ready low).

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE, data_out=0, data_out_valid=0, done=0, busy=0, data_ready=0, counters and holding register 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL wait in IDLE for start and emit no stale output.

Verification
REQ-034 Default params, start, inputs ch0 = 0x0100, 0xFF00, 0x0080, 0x0200 ... with data_out_ready=1 -> outputs 0x0100 (max(256,-64)), 0x0200, ...; 32 outputs then done pulse.
REQ-035 ACT_EN=1, pair (-512, -1024) -> output 0xFF80 (max(-128,-256)); pair (-1, -3) -> 0xFFFF.
REQ-036 data_out_ready held low 5 cycles with data_out_valid=1 -> data_out stable, data_ready low, no input lost; releasing gives continuous transfers.
REQ-037 POOL=1, FRAME_LEN=4, NUM_CH=2, random data_valid gaps -> 8 outputs equal to per-sample activation, done after last handshake.
REQ-038 Pair straddling channel boundary (ch0 pos15=0x7FFF, ch1 pos0=0x0000) -> ch0 final output uses pos14/pos15 only; ch1 first output uses pos0/pos1.
REQ-039 rst_n pulse after 10 accepted inputs -> all outputs zero/low immediately; new start and full frame produce correct 32 outputs.
